// File: rtl/hello_world_qsys_poller_pkg.sv
// hello_world_qsys_poller_pkg: poll FSM encoding and Avalon constants shared by the switch poller.
package hello_world_qsys_poller_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} poll_state_t;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int READ_LATENCY = 1;
endpackage

// File: rtl/hello_world_qsys_switch_poller_if.sv
// hello_world_qsys_switch_poller_if: Avalon-MM read-only link between the poller and the switch PIO.
interface hello_world_qsys_switch_poller_if;
  logic [1:0] address;
  logic read;
  logic [31:0] readdata;
  modport master(output address, read, input readdata);
  modport slave(input address, read, output readdata);
endinterface

// File: rtl/hello_world_qsys_debounce.sv
// hello_world_qsys_debounce: accepts a sample after STABLE_CNT identical polls and emits rise/fall strobes.
module hello_world_qsys_debounce #(
  parameter int DATA_W = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_valid,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall
);
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  logic [DATA_W-1:0] candidate;
  logic [3:0] count, count_next;
  logic accept;
  always_comb begin
    count_next = sample != candidate ? 4'd1 : count == STABLE ? count : count + 4'd1;
    // a saturated count must not re-accept, except that STABLE_CNT=1 accepts every poll
    accept = sample_en && count_next == STABLE && (STABLE_CNT == 1 || count != STABLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '0;
      count <= '0;
      sw_state <= '0;
      sw_valid <= 1'b0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      if (sample_en) begin
        candidate <= sample;
        count <= count_next;
      end
      if (accept && !sw_valid) begin
        sw_state <= sample;
        sw_valid <= 1'b1;
      end else if (accept && sample != sw_state) begin
        sw_rise <= sample & ~sw_state;
        sw_fall <= ~sample & sw_state;
        sw_state <= sample;
      end
    end
  end
endmodule

// File: rtl/hello_world_qsys_switch_poller.sv
// hello_world_qsys_switch_poller: periodic Avalon-MM poll of the switch PIO with debounce; SWITCH_POLLER_IRQ_EN adds irq/irq_ack.
module hello_world_qsys_switch_poller
  import hello_world_qsys_poller_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int POLL_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  hello_world_qsys_switch_poller_if.master avm,
`ifdef SWITCH_POLLER_IRQ_EN
  output logic              irq,
  input  logic              irq_ack,
`endif
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_valid,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall
);
  localparam int TW = POLL_DIV > 1 ? $clog2(POLL_DIV) : 1;
  if (POLL_DIV < 3 + READ_LATENCY) begin : g_bad_div
    $error("POLL_DIV too small for one read transaction");
  end
  if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_cnt
    $error("STABLE_CNT out of range 1..15");
  end
  poll_state_t state;
  logic [TW-1:0] timer;
  logic read, sample_en;
  logic [DATA_W-1:0] sample;
  logic unused_readdata;
  assign unused_readdata = ^avm.readdata;
  assign avm.address = PIO_DATA_ADDR;
  assign avm.read = read;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      state <= IDLE;
      read <= 1'b0;
      sample_en <= 1'b0;
      sample <= '0;
    end else begin
      timer <= timer == TW'(POLL_DIV - 1) ? '0 : timer + TW'(1);
      // leave IDLE one cycle early so the read strobe lands on the terminal count
      case (state)
        IDLE: if (timer == TW'(POLL_DIV - 2)) begin
          state <= ISSUE;
          read <= 1'b1;
        end
        ISSUE: begin
          state <= WAIT;
          read <= 1'b0;
        end
        // readdata is only valid now, so register it for the debouncer to consume in CAPTURE
        WAIT: begin
          state <= CAPTURE;
          sample <= avm.readdata[DATA_W-1:0];
          sample_en <= 1'b1;
        end
        default: begin
          state <= IDLE;
          sample_en <= 1'b0;
        end
      endcase
    end
  end
  hello_world_qsys_debounce #(.DATA_W(DATA_W), .STABLE_CNT(STABLE_CNT)) u_debounce (
    .clk(clk),
    .reset_n(reset_n),
    .sample_en(sample_en),
    .sample(sample),
    .sw_state(sw_state),
    .sw_valid(sw_valid),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );
`ifdef SWITCH_POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= |(sw_rise | sw_fall) ? 1'b1 : irq_ack ? 1'b0 : irq;
  end
`endif
endmodule

// File: tb/tb_hello_world_qsys_switch_poller.sv
// tb_hello_world_qsys_switch_poller: randomized poll stimulus checked against a run-length debounce model.
module tb_hello_world_qsys_switch_poller;
  localparam int PD = 8;
  localparam int SC = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  hello_world_qsys_switch_poller_if bus();
  logic [1:0] sw_state, sw_rise, sw_fall;
  logic sw_valid;
  logic irq_ack = 1'b0;
`ifdef SWITCH_POLLER_IRQ_EN
  logic irq;
`endif
  hello_world_qsys_switch_poller #(.DATA_W(2), .POLL_DIV(PD), .STABLE_CNT(SC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm(bus),
`ifdef SWITCH_POLLER_IRQ_EN
    .irq(irq),
    .irq_ack(irq_ack),
`endif
    .sw_state(sw_state),
    .sw_valid(sw_valid),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );
  int checks = 0, errors = 0, cyc = 0, last_rd = 0;
  bit have_rd = 0;
  logic [1:0] sw_in = 2'b00;
  logic rd_was;
  logic [1:0] hist[$];
  logic [1:0] m_state = 2'b00;
  logic m_valid = 1'b0;
  always @(posedge clk) cyc++;
  // slave with latency 1: real data only in the cycle after read, garbage otherwise
  always @(posedge clk) begin
    rd_was = bus.read;
    #1 bus.readdata = rd_was ? {30'($urandom), sw_in} : $urandom;
  end
  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({bus.read, sw_state, sw_valid, sw_rise, sw_fall} !== 8'h00) begin
      errors++;
      $display("FAIL %s outputs got read=%b state=%b valid=%b rise=%b fall=%b exp all 0", tag, bus.read, sw_state, sw_valid, sw_rise, sw_fall);
    end
  endtask
  task automatic release_and_check();
    hist.delete();
    m_valid = 1'b0;
    m_state = 2'b00;
    have_rd = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < PD; c++) begin
      checks++;
      if (bus.read !== (c == PD - 1)) begin
        errors++;
        $display("FAIL first_read cycle %0d got %b exp %b", c, bus.read, c == PD - 1);
      end
      if (c < PD - 1) @(negedge clk);
    end
  endtask
  task automatic poll(input logic [1:0] v, input bit ack_strobe);
    int n = 0, run = 0;
    logic [1:0] er = 2'b00, ef = 2'b00;
    sw_in = v;
    while (bus.read !== 1'b1 && n < 2 * PD) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.read !== 1'b1 || bus.address !== 2'd0) begin
      errors++;
      $display("FAIL read_issue got read=%b addr=%0d exp read=1 addr=0", bus.read, bus.address);
      return;
    end
    if (have_rd) begin
      checks++;
      if (cyc - last_rd != PD) begin
        errors++;
        $display("FAIL read_period got %0d exp %0d", cyc - last_rd, PD);
      end
    end
    last_rd = cyc;
    have_rd = 1;
    @(negedge clk);
    checks++;
    if (bus.read !== 1'b0) begin
      errors++;
      $display("FAIL read_width got %b exp 0", bus.read);
    end
    @(negedge clk);
    @(negedge clk);
    hist.push_back(v);
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != v) break;
      run++;
    end
    if (run == SC && !m_valid) begin
      m_valid = 1'b1;
      m_state = v;
    end else if (run == SC) begin
      er = v & ~m_state;
      ef = ~v & m_state;
      m_state = v;
    end
    checks++;
    if (sw_state !== m_state || sw_valid !== m_valid || sw_rise !== er || sw_fall !== ef) begin
      errors++;
      $display("FAIL poll_%b got state=%b valid=%b rise=%b fall=%b exp state=%b valid=%b rise=%b fall=%b",
               v, sw_state, sw_valid, sw_rise, sw_fall, m_state, m_valid, er, ef);
    end
    irq_ack = ack_strobe;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (sw_rise !== 2'b00 || sw_fall !== 2'b00 || sw_state !== m_state) begin
      errors++;
      $display("FAIL strobe_clear got rise=%b fall=%b state=%b exp 00 00 %b", sw_rise, sw_fall, sw_state, m_state);
    end
  endtask
  task automatic test_reset();
    #1 check_idle_outputs("reset");
    release_and_check();
  endtask
  task automatic test_first_accept();
    for (int i = 0; i < SC; i++) poll(2'b10, 0);
  endtask
  task automatic test_rise_fall();
    for (int i = 0; i < SC; i++) poll(2'b11, 0);
    for (int i = 0; i < SC; i++) poll(2'b00, 0);
  endtask
  task automatic test_glitch();
    for (int i = 0; i < SC; i++) poll(2'b11, 0);
    poll(2'b01, 0);
    for (int i = 0; i < SC; i++) poll(2'b11, 0);
  endtask
  task automatic test_random();
    logic [1:0] v = 2'b11;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) v = 2'($urandom);
      poll(v, 0);
    end
  endtask
  task automatic test_mid_reset();
    int n = 0;
    while (bus.read !== 1'b1 && n < 2 * PD) begin
      @(negedge clk);
      n++;
    end
    #1 reset_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    release_and_check();
    for (int i = 0; i < SC; i++) poll(2'b01, 0);
  endtask
`ifdef SWITCH_POLLER_IRQ_EN
  task automatic test_irq();
    for (int i = 0; i < SC; i++) poll(2'b10, 0);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b exp 1", irq);
    end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack got %b exp 0", irq);
    end
    for (int i = 0; i < SC - 1; i++) poll(2'b01, 0);
    poll(2'b01, 1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins got %b exp 1", irq);
    end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_first_accept();
    test_rise_fall();
    test_glitch();
    test_random();
    test_mid_reset();
`ifdef SWITCH_POLLER_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
